hht_mchan_fifo: RTL

- Parametrised multi-channel memory-side buffer between the HHT backend/frontend request engines and the memory return path.
- Replaces the separate fixed 8x32 backend and frontend buffers with a single block.
- NUM_CH independent write channels, each with its own circular FIFO, share one read port drained by a round-robin arbiter.
- Adds exact full/empty at full DEPTH occupancy, per-channel fill level, almost-full, and sticky overflow/underflow error flags.

---
 rtl/hht_mchan_fifo_if.sv | 34 +++
 rtl/hht_mchan_fifo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hht_mchan_fifo_if.sv
// Bus bundle for hht_mchan_fifo: per-channel write side, shared read side and
// status/error flags. The FIFO takes the slave view, the request engines the master view.
interface hht_mchan_fifo_if #(
    parameter int DW     = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_CH = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]          wr_en;
    logic [NUM_CH*DW-1:0]       wr_data;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          afull;
    logic [NUM_CH*(AW+1)-1:0]   level;
    logic                       rd_en;
    logic [DW-1:0]              rd_data;
    logic                       rd_valid;
    logic [CW-1:0]              rd_ch;
    logic                       empty;
    logic [NUM_CH-1:0]          ovf;
    logic                       udf;
    logic                       clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  full, afull, level, rd_data, rd_valid, rd_ch, empty, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output full, afull, level, rd_data, rd_valid, rd_ch, empty, ovf, udf
    );
endinterface

// File: rtl/hht_mchan_fifo.sv
// Multi-channel circular FIFO with a round-robin drained shared read port.
// Define HHT_FIFO_FWFT_EN for a first-word-fall-through read port.
module hht_mchan_fifo #(
    parameter int DW       = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_CH   = 2,
    parameter int AF_LEVEL = 6
) (
    input  logic            clk,
    input  logic            reset,
    hht_mchan_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
    localparam logic [CW-1:0] LAST_RST = CW'(NUM_CH - 1);

    logic [DW-1:0]     mem_q    [NUM_CH][DEPTH];
    logic [AW-1:0]     wr_ptr_q [NUM_CH];
    logic [AW-1:0]     wr_ptr_d [NUM_CH];
    logic [AW-1:0]     rd_ptr_q [NUM_CH];
    logic [AW-1:0]     rd_ptr_d [NUM_CH];
    logic [LW-1:0]     level_q  [NUM_CH];
    logic [LW-1:0]     level_d  [NUM_CH];
    logic [CW-1:0]     last_q, last_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic [NUM_CH-1:0] full, afull, wr_fire;
    logic              empty;
    logic              grant_vld;
    logic [CW-1:0]     grant_ch;
    logic              pop;
    logic [DW-1:0]     head_data;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
        return CW'((int'(base) + k) % NUM_CH);
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        full    = '0;
        afull   = '0;
        wr_fire = '0;
        empty   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]    = (level_q[i] == FULL_LVL);
            afull[i]   = (level_q[i] >= AF_LVL);
            wr_fire[i] = bus.wr_en[i] && !full[i];
            if (level_q[i] != '0) empty = 1'b0;
        end
    end

    // Walk from furthest to nearest candidate so the one right after last_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (level_q[rr_idx(last_q, k)] != '0) begin
                grant_vld = 1'b1;
                grant_ch  = rr_idx(last_q, k);
            end
        end
        head_data = mem_q[grant_ch][rd_ptr_q[grant_ch]];
    end

    assign pop = bus.rd_en && grant_vld;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        last_d   = last_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_fire[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
            if (pop && grant_ch == CW'(i)) rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
            level_d[i] = level_q[i] + LW'(wr_fire[i]) - LW'(pop && grant_ch == CW'(i));
        end
        if (pop) last_d = grant_ch;
        ovf_d = (bus.clr_err ? '0 : ovf_q) | (bus.wr_en & full);
        udf_d = (bus.clr_err ? 1'b0 : udf_q) | (bus.rd_en & empty);
    end

    // NOTE: storage has no reset; pointers and levels alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_fire[i]) mem_q[i][wr_ptr_q[i]] <= bus.wr_data[i*DW +: DW];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            level_q  <= '{default: '0};
            last_q   <= LAST_RST;
            ovf_q    <= '0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef HHT_FIFO_FWFT_EN
    assign bus.rd_valid = grant_vld;
    assign bus.rd_data  = head_data;
    assign bus.rd_ch    = grant_ch;
`else
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [CW-1:0] rd_ch_q, rd_ch_d;

    always_comb begin
        rd_valid_d = pop;
        rd_data_d  = pop ? head_data : rd_data_q;
        rd_ch_d    = pop ? grant_ch  : rd_ch_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_ch_q    <= rd_ch_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_ch    = rd_ch_q;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_level
        assign bus.level[g*LW +: LW] = level_q[g];
    end

    assign bus.full  = full;
    assign bus.afull = afull;
    assign bus.empty = empty;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;
endmodule
